// File: rtl/xor_sweep_pkg.sv
// Shared definitions for the XOR equivalence sweep: FSM state encoding and the golden XOR.
package xor_sweep_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Reference result; callers pass zero-extended operands and truncate the result.
    function automatic logic [31:0] xor_golden(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/xor_sweep_controller.sv
// Sweeps every operand pair through two XOR implementations, compares them against the golden
// XOR, counts mismatches and captures the first failing vector.
module xor_sweep_controller
    import xor_sweep_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     res_beh,
    input  logic [WIDTH-1:0]     res_str,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [1:0]           state_dbg
);

    localparam int VW  = 2 * WIDTH;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic             fev_q, fev_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic             pass_q, pass_d;
    logic             err_inc, err_clr;
    logic             start_ok;
    logic             vec_last;
    logic             mismatch;
    logic [WIDTH-1:0] golden;

    // op_b occupies the LSBs so the sweep order is 00,01,10,11 for WIDTH=1.
    assign op_a     = vec_q[VW-1:WIDTH];
    assign op_b     = vec_q[WIDTH-1:0];
    assign vec_last = &vec_q;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign golden   = WIDTH'(xor_golden(32'(op_a), 32'(op_b)));
    assign mismatch = (res_beh != res_str) || (res_beh != golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
            ST_SETTLE:        if (settle_q == '0) state_d = ST_CHECK;
            ST_CHECK:         state_d = vec_last ? ST_DONE : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done      = (state_q == ST_DONE);
        state_dbg = state_q;
    end

    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        fev_d    = fev_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        pass_d   = pass_q;
        err_inc  = 1'b0;
        err_clr  = 1'b0;
        if (start_ok) begin
            vec_d    = '0;
            settle_d = SETTLE_LOAD;
            fev_d    = 1'b0;
            fa_d     = '0;
            fb_d     = '0;
            pass_d   = 1'b0;
            err_clr  = 1'b1;
        end else if (state_q == ST_SETTLE) begin
            if (settle_q != '0) settle_d = settle_q - 1'b1;
        end else if (state_q == ST_CHECK) begin
            err_inc = mismatch;
            if (mismatch && !fev_q) begin
                fev_d = 1'b1;
                fa_d  = op_a;
                fb_d  = op_b;
            end
            // The last compare lands on this edge, so pass must fold in its own mismatch.
            if (vec_last) begin
                pass_d = (err_count == '0) && !mismatch;
            end else begin
                vec_d    = vec_q + 1'b1;
                settle_d = SETTLE_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            settle_q <= '0;
            fev_q    <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            fev_q    <= fev_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            pass_q   <= pass_d;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (err_clr),
        .cnt (err_count)
    );

    assign pass            = pass_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fa_q;
    assign first_err_b     = fb_q;

endmodule
